// File: rtl/cr_osf_dbg_mch_fifo_ctl_pkg.sv
// +----------------------------------------------------------------------------+
// | cr_osfPKG : shared types and constants for the OSF debug-FIFO controller   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package cr_osfPKG;

    typedef enum logic [1:0] {
        DBG_OFF   = 2'd0,
        DBG_CAPT  = 2'd1,
        DBG_STEP  = 2'd2,
        DBG_DRAIN = 2'd3
    } dbg_mode_e;

    typedef enum logic [2:0] {
        ST_PASS   = 3'd0,
        ST_CAPT   = 3'd1,
        ST_FROZEN = 3'd2,
        ST_STEP   = 3'd3,
        ST_DRAIN  = 3'd4
    } dbg_state_e;

    localparam int DBG_FULL_MARGIN_DFLT = 2;

endpackage

`default_nettype wire

// File: rtl/cr_osf_dbg_mch_fifo_ctl_chan.sv
// +----------------------------------------------------------------------------+
// | cr_osf_dbg_chan_ctl : one channel of the debug-FIFO flow controller        |
// | Optional statistics counters enabled by CR_OSF_DBG_STAT_EN.                |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module cr_osf_dbg_chan_ctl
    import cr_osfPKG::*;
#(
    parameter int DEPTH       = 64,
    parameter int FULL_MARGIN = DBG_FULL_MARGIN_DFLT,
    parameter int STEP_CNT_W  = 4,
    parameter int STAT_W      = 16,
    localparam int DW         = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        debug_mode,
    input  logic              single_step_rd,
    input  logic              src_empty,
    output logic              src_rd,
    input  logic [DW-1:0]     dbg_fifo_depth,
    output logic              dbg_fifo_hw_wr,
    output logic              dbg_fifo_hw_rd,
    input  logic              ob_afull,
    output logic              ob_wr,
    output logic              dbg_frozen,
    input  logic              stat_clr,
    output logic [STAT_W-1:0] stat_wr_cnt,
    output logic [STAT_W-1:0] stat_rd_cnt
);

    localparam logic [DW-1:0]         C_FULL_TH  = DW'(DEPTH - FULL_MARGIN);
    localparam logic [STEP_CNT_W-1:0] C_CRED_MAX = '1;

    dbg_mode_e             r_mode;
    dbg_state_e            r_state;
    dbg_state_e            w_state_nxt;
    logic [STEP_CNT_W-1:0] r_credit;
    logic                  r_ob_wr;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_wen;
    logic                  w_ren;
    logic                  w_hw_wr;
    logic                  w_hw_rd;

    assign w_empty = (dbg_fifo_depth == '0);
    assign w_full  = (dbg_fifo_depth >= C_FULL_TH);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode  <= DBG_OFF;
            r_state <= ST_PASS;
        end else begin
            r_mode  <= dbg_mode_e'(debug_mode);
            r_state <= w_state_nxt;
        end
    end

    // Mode selects the state directly; CAPT only refines into FROZEN.
    always_comb begin
        w_state_nxt = ST_PASS;
        w_wen       = 1'b0;
        w_ren       = 1'b0;
        unique case (r_mode)
            DBG_OFF:   w_state_nxt = ST_PASS;
            DBG_CAPT:  w_state_nxt = ((r_state == ST_CAPT && w_full) || r_state == ST_FROZEN)
                                     ? ST_FROZEN : ST_CAPT;
            DBG_STEP:  w_state_nxt = ST_STEP;
            DBG_DRAIN: w_state_nxt = ST_DRAIN;
            default:   w_state_nxt = ST_PASS;
        endcase
        unique case (r_state)
            ST_PASS:   begin w_wen = 1'b1; w_ren = 1'b1; end
            ST_CAPT:   w_wen = 1'b1;
            ST_STEP:   w_ren = (r_credit != '0);
            ST_DRAIN:  w_ren = 1'b1;
            default:   begin w_wen = 1'b0; w_ren = 1'b0; end
        endcase
    end

    assign w_hw_wr        = !rst && w_wen && !src_empty && !w_full;
    assign w_hw_rd        = !rst && w_ren && !w_empty && !ob_afull;
    assign dbg_fifo_hw_wr = w_hw_wr;
    assign src_rd         = w_hw_wr;
    assign dbg_fifo_hw_rd = w_hw_rd;
    assign dbg_frozen     = (r_state == ST_FROZEN);
    assign ob_wr          = r_ob_wr;

    // Credits only live while staying in STEP; a read in STEP implies credit > 0.
    always_ff @(posedge clk) begin
        if (rst || r_state != ST_STEP || w_state_nxt != ST_STEP) begin
            r_credit <= '0;
        end else if (single_step_rd && !w_hw_rd) begin
            if (r_credit != C_CRED_MAX) begin
                r_credit <= r_credit + 1'b1;
            end
        end else if (!single_step_rd && w_hw_rd) begin
            r_credit <= r_credit - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ob_wr <= 1'b0;
        end else begin
            r_ob_wr <= w_hw_rd && !ob_afull;
        end
    end

`ifdef CR_OSF_DBG_STAT_EN
    logic [STAT_W-1:0] r_stat_wr;
    logic [STAT_W-1:0] r_stat_rd;

    always_ff @(posedge clk) begin
        if (rst || stat_clr) begin
            r_stat_wr <= '0;
            r_stat_rd <= '0;
        end else begin
            if (w_hw_wr && r_stat_wr != '1) begin
                r_stat_wr <= r_stat_wr + 1'b1;
            end
            if (w_hw_rd && r_stat_rd != '1) begin
                r_stat_rd <= r_stat_rd + 1'b1;
            end
        end
    end

    assign stat_wr_cnt = r_stat_wr;
    assign stat_rd_cnt = r_stat_rd;
`else
    logic w_unused_stat_clr;

    assign w_unused_stat_clr = stat_clr;
    assign stat_wr_cnt       = '0;
    assign stat_rd_cnt       = '0;
`endif

endmodule

`default_nettype wire

// File: rtl/cr_osf_dbg_mch_fifo_ctl.sv
// +----------------------------------------------------------------------------+
// | cr_osf_dbg_mch_fifo_ctl : N_CH independent debug-FIFO flow controllers     |
// | Optional statistics counters enabled by CR_OSF_DBG_STAT_EN.                |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module cr_osf_dbg_mch_fifo_ctl
    import cr_osfPKG::*;
#(
    parameter int N_CH        = 2,
    parameter int DEPTH       = 64,
    parameter int FULL_MARGIN = DBG_FULL_MARGIN_DFLT,
    parameter int STEP_CNT_W  = 4,
    parameter int STAT_W      = 16,
    localparam int DW         = $clog2(DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_CH*2-1:0]        debug_mode,
    input  logic [N_CH-1:0]          single_step_rd,
    input  logic [N_CH-1:0]          src_empty,
    output logic [N_CH-1:0]          src_rd,
    input  logic [N_CH*DW-1:0]       dbg_fifo_depth,
    output logic [N_CH-1:0]          dbg_fifo_hw_wr,
    output logic [N_CH-1:0]          dbg_fifo_hw_rd,
    input  logic [N_CH-1:0]          ob_afull,
    output logic [N_CH-1:0]          ob_wr,
    output logic [N_CH-1:0]          dbg_frozen,
    input  logic                     stat_clr,
    output logic [N_CH*STAT_W-1:0]   stat_wr_cnt,
    output logic [N_CH*STAT_W-1:0]   stat_rd_cnt
);

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        cr_osf_dbg_chan_ctl #(
            .DEPTH       (DEPTH),
            .FULL_MARGIN (FULL_MARGIN),
            .STEP_CNT_W  (STEP_CNT_W),
            .STAT_W      (STAT_W)
        ) u_chan (
            .clk            (clk),
            .rst            (rst),
            .debug_mode     (debug_mode[gi*2 +: 2]),
            .single_step_rd (single_step_rd[gi]),
            .src_empty      (src_empty[gi]),
            .src_rd         (src_rd[gi]),
            .dbg_fifo_depth (dbg_fifo_depth[gi*DW +: DW]),
            .dbg_fifo_hw_wr (dbg_fifo_hw_wr[gi]),
            .dbg_fifo_hw_rd (dbg_fifo_hw_rd[gi]),
            .ob_afull       (ob_afull[gi]),
            .ob_wr          (ob_wr[gi]),
            .dbg_frozen     (dbg_frozen[gi]),
            .stat_clr       (stat_clr),
            .stat_wr_cnt    (stat_wr_cnt[gi*STAT_W +: STAT_W]),
            .stat_rd_cnt    (stat_rd_cnt[gi*STAT_W +: STAT_W])
        );
    end

endmodule

`default_nettype wire
